// File: rtl/time_keeper.sv
// BCD hh:mm:ss timekeeper driven by divider ticks, with a set mode; HOUR12_EN selects the 12 h build.
// Latency: one clk from a sampled tick or inc pulse to the registered time and strobes.
// Backpressure: none; every tick is consumed, and ticks are discarded while set_mode is high.
module time_keeper #(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hr,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_wrap
);

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

`ifdef HOUR12_EN
    localparam logic [7:0] HR_RESET = 8'h12;
`else
    localparam logic [7:0] HR_RESET = 8'h00;
`endif

    // Two-digit BCD increment that wraps from last back to first.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] last,
                                           input logic [7:0] first);
        logic [7:0] r;
        if (v == last)
            r = first;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    logic [15:0] prescale;
    logic        pm_q;
    logic        advance;
    logic        sec_wrap;
    logic        min_wrap;
    logic        hr_toggles_pm;
    logic        at_day_end;
    logic [7:0]  sec_next;
    logic [7:0]  min_next;
    logic [7:0]  hr_next;

    assign advance  = !set_mode && tick && (prescale == DIV_LAST);
    assign sec_wrap = (sec == 8'h59);
    assign min_wrap = (min == 8'h59);
    assign sec_next = bcd_inc(sec, 8'h59, 8'h00);
    assign min_next = bcd_inc(min, 8'h59, 8'h00);

`ifdef HOUR12_EN
    // 12 h clock: 12 -> 01 keeps the half-day, 11 -> 12 crosses noon/midnight.
    assign hr_next       = bcd_inc(hr, 8'h12, 8'h01);
    assign hr_toggles_pm = (hr == 8'h11);
    assign at_day_end    = (hr == 8'h11) && pm_q;
`else
    assign hr_next       = bcd_inc(hr, 8'h23, 8'h00);
    assign hr_toggles_pm = 1'b0;
    assign at_day_end    = (hr == 8'h23);
`endif

    assign pm = pm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale  <= '0;
            sec       <= 8'h00;
            min       <= 8'h00;
            hr        <= HR_RESET;
            pm_q      <= 1'b0;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
        end else begin
            sec_pulse <= advance;
            day_wrap  <= advance && sec_wrap && min_wrap && at_day_end;
            if (set_mode) begin
                prescale <= '0;
                sec      <= 8'h00;
                if (inc_min)
                    min <= min_next;
                if (inc_hr) begin
                    hr   <= hr_next;
                    pm_q <= pm_q ^ hr_toggles_pm;
                end
            end else if (tick) begin
                prescale <= advance ? 16'd0 : prescale + 16'd1;
                if (advance) begin
                    sec <= sec_next;
                    if (sec_wrap) begin
                        min <= min_next;
                        if (min_wrap) begin
                            hr   <= hr_next;
                            pm_q <= pm_q ^ hr_toggles_pm;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: instances with TICK_DIV=1 and TICK_DIV=4 against a seconds-of-day model.
module tb_time_keeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0, set_mode = 1'b0, inc_min = 1'b0, inc_hr = 1'b0;
    logic [1:0][7:0] sec_o, min_o, hr_o;
    logic [1:0]      pm_o, pulse_o, wrap_o;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    time_keeper #(.TICK_DIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hr(inc_hr), .sec(sec_o[0]), .min(min_o[0]),
        .hr(hr_o[0]), .pm(pm_o[0]), .sec_pulse(pulse_o[0]), .day_wrap(wrap_o[0]));

    time_keeper #(.TICK_DIV(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hr(inc_hr), .sec(sec_o[1]), .min(min_o[1]),
        .hr(hr_o[1]), .pm(pm_o[1]), .sec_pulse(pulse_o[1]), .day_wrap(wrap_o[1]));

    // Model: time as seconds since midnight, plus the number of ticks since the last advance.
    int  divs [2] = '{1, 4};
    int  t    [2];
    int  pc   [2];
    bit  mp   [2];
    bit  mw   [2];

    always @(posedge clk or negedge rst_n) begin
        int h, m;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                t[k] = 0; pc[k] = 0; mp[k] = 0; mw[k] = 0;
            end else begin
                mp[k] = 0; mw[k] = 0;
                if (set_mode) begin
                    h = t[k] / 3600;
                    m = (t[k] / 60) % 60;
                    if (inc_min) m = (m + 1) % 60;
                    if (inc_hr)  h = (h + 1) % 24;
                    t[k]  = h * 3600 + m * 60;
                    pc[k] = 0;
                end else if (tick) begin
                    pc[k] = pc[k] + 1;
                    if (pc[k] == divs[k]) begin
                        pc[k] = 0;
                        t[k]  = (t[k] + 1) % 86400;
                        mp[k] = 1;
                        mw[k] = (t[k] == 0);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] hr_exp(input int tt);
        int h;
        h = tt / 3600;
`ifdef HOUR12_EN
        return bcd((h % 12 == 0) ? 12 : h % 12);
`else
        return bcd(h);
`endif
    endfunction

    function automatic logic pm_exp(input int tt);
`ifdef HOUR12_EN
        return (tt / 3600) >= 12;
`else
        return (tt < 0);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("sec[%0d]", k),   32'(sec_o[k]),   32'(bcd(t[k] % 60)));
            chk($sformatf("min[%0d]", k),   32'(min_o[k]),   32'(bcd((t[k] / 60) % 60)));
            chk($sformatf("hr[%0d]", k),    32'(hr_o[k]),    32'(hr_exp(t[k])));
            chk($sformatf("pm[%0d]", k),    32'(pm_o[k]),    32'(pm_exp(t[k])));
            chk($sformatf("pulse[%0d]", k), 32'(pulse_o[k]), 32'(mp[k]));
            chk($sformatf("wrap[%0d]", k),  32'(wrap_o[k]),  32'(mw[k]));
        end
    end

    // Drives one cycle of inputs; returns 2 time units after the edge that sampled them.
    task automatic cyc(input bit tk, input bit sm, input bit im, input bit ih);
        tick = tk; set_mode = sm; inc_min = im; inc_hr = ih;
        @(posedge clk);
        #2;
        tick = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic set_time(input int h, input int m);
        for (int i = 0; i < h; i++) cyc(0, 1, 0, 1);
        for (int i = 0; i < m; i++) cyc(0, 1, 1, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    initial begin
        do_reset();
`ifdef HOUR12_EN
        chk("lit_reset_hr", 32'(hr_o[0]), 32'h12);
`else
        chk("lit_reset_hr", 32'(hr_o[0]), 32'h00);
`endif
        chk("lit_reset_sec", 32'(sec_o[0]), 32'h00);

        // One tick at TICK_DIV=1: next edge shows 01 with a single-cycle strobe.
        cyc(1, 0, 0, 0);
        chk("lit_first_sec", 32'(sec_o[0]), 32'h01);
        chk("lit_first_pulse", 32'(pulse_o[0]), 32'h1);
        cyc(0, 0, 0, 0);
        chk("lit_pulse_drop", 32'(pulse_o[0]), 32'h0);

        // Asynchronous reset mid-count, checked before any clk edge.
        ticks(5);
        #1 rst_n = 1'b0;
        #1;
        chk("lit_async_sec", 32'(sec_o[0]), 32'h00);
        chk("lit_async_pulse", 32'(pulse_o[0]), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // 01:23:00 via set mode, then 60 seconds of counting.
        set_time(1, 23);
        chk("lit_set_hr", 32'(hr_o[0]), 32'h01);
        chk("lit_set_min", 32'(min_o[0]), 32'h23);
        ticks(10);
        chk("lit_sec_10", 32'(sec_o[0]), 32'h10);
        ticks(50);
        chk("lit_0124_min", 32'(min_o[0]), 32'h24);
        chk("lit_0124_sec", 32'(sec_o[0]), 32'h00);

        // End of day: 23:59:59 -> 00:00:00 with day_wrap.
        do_reset();
        set_time(23, 59);
        ticks(59);
        chk("lit_2359_sec", 32'(sec_o[0]), 32'h59);
        ticks(1);
        chk("lit_wrap_flag", 32'(wrap_o[0]), 32'h1);
        chk("lit_wrap_pulse", 32'(pulse_o[0]), 32'h1);
`ifdef HOUR12_EN
        chk("lit_wrap_hr", 32'(hr_o[0]), 32'h12);
        chk("lit_wrap_pm", 32'(pm_o[0]), 32'h0);
`else
        chk("lit_wrap_hr", 32'(hr_o[0]), 32'h00);
`endif
        cyc(0, 0, 0, 0);
        chk("lit_wrap_drop", 32'(wrap_o[0]), 32'h0);

        // Noon crossing and the 12 -> 1 step.
        do_reset();
        set_time(11, 59);
        ticks(60);
`ifdef HOUR12_EN
        chk("lit_noon_hr", 32'(hr_o[0]), 32'h12);
        chk("lit_noon_pm", 32'(pm_o[0]), 32'h1);
`else
        chk("lit_noon_hr", 32'(hr_o[0]), 32'h12);
`endif
        set_time(0, 59);
        ticks(60);
`ifdef HOUR12_EN
        chk("lit_one_hr", 32'(hr_o[0]), 32'h01);
        chk("lit_one_pm", 32'(pm_o[0]), 32'h1);
`else
        chk("lit_one_hr", 32'(hr_o[0]), 32'h13);
`endif

        // TICK_DIV=4: advance only on every 4th tick; set mode clears the prescaler.
        do_reset();
        ticks(7);
        chk("lit_div4_sec", 32'(sec_o[1]), 32'h01);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        ticks(3);
        chk("lit_div4_hold", 32'(sec_o[1]), 32'h00);
        ticks(1);
        chk("lit_div4_adv", 32'(sec_o[1]), 32'h01);

        // Simultaneous increments, ticks ignored in set mode, inc ignored when running.
        do_reset();
        set_time(5, 59);
        cyc(0, 1, 1, 1);
        chk("lit_0600_hr", 32'(hr_o[0]), 32'h06);
        chk("lit_0600_min", 32'(min_o[0]), 32'h00);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("lit_set_tick_sec", 32'(sec_o[0]), 32'h00);
        cyc(0, 0, 1, 1);
        chk("lit_run_inc_min", 32'(min_o[0]), 32'h00);
        chk("lit_run_inc_hr", 32'(hr_o[0]), 32'h06);
        cyc(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
